// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX core among N_REQ byte sources; a winner keeps the
// transmitter until its `last` byte is sent. Define TX_ARB_TIMEOUT_EN to build the HOLD stall timeout.
module uart_tx_arb #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               lock_drop
);
  localparam int IW = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
    $error("uart_tx_arb: N_REQ must be in 2..4");
  end
  if (TIMEOUT < 1 || TIMEOUT > 134217727) begin : g_bad_timeout
    $error("uart_tx_arb: TIMEOUT must be in 1..2^27-1");
  end

  state_t        state;
  logic [IW-1:0] rr_ptr, owner, win, sel, cand;
  logic          win_found, accept, last_q;
  logic [7:0]    lane [N_REQ];

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) lane[i] = req_data[8*i +: 8];
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    sel       = win;
    if (state == IDLE && win_found) begin
      accept = 1'b1;
    end else if (state == HOLD && req_valid[owner]) begin
      accept = 1'b1;
      sel    = owner;
    end
    if (accept) req_ready[sel] = 1'b1;
  end

`ifdef TX_ARB_TIMEOUT_EN
  logic [26:0] hold_cnt;
`else
  assign lock_drop = 1'b0;
`endif

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      last_q   <= 1'b0;
      grant    <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
      lock_drop <= 1'b0;
      hold_cnt  <= '0;
`endif
    end else begin
      tx_start <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
      lock_drop <= 1'b0;
`endif
      if (accept) begin
        tx_data  <= lane[sel];
        last_q   <= req_last[sel];
        owner    <= sel;
        grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
        tx_start <= 1'b1;
        state    <= START;
      end else begin
        case (state)
          START: state <= WAIT;
          WAIT: begin
            if (!tx_busy) begin
              if (last_q) begin
                state  <= IDLE;
                grant  <= '0;
                rr_ptr <= next_idx(owner);
              end else begin
                state <= HOLD;
`ifdef TX_ARB_TIMEOUT_EN
                hold_cnt <= '0;
`endif
              end
            end
          end
`ifdef TX_ARB_TIMEOUT_EN
          HOLD: begin
            // Owner went quiet mid-message: release the lock and move the pointer past it.
            if (hold_cnt == 27'(TIMEOUT - 1)) begin
              lock_drop <= 1'b1;
              state     <= IDLE;
              grant     <= '0;
              rr_ptr    <= next_idx(owner);
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb (N_REQ=4, TIMEOUT=20): vector table, directed sequences
// and randomized messages checked against a message-level round-robin model.
module tb_uart_tx_arb;
  localparam int N = 4;

  typedef struct { logic [7:0] data; logic last; } item_t;
  typedef struct { logic [7:0] data; logic [N-1:0] grant; int cyc; } txev_t;
  typedef struct { int prev; logic [N-1:0] valid; logic [N-1:0] exp_ready; logic [7:0] exp_data; } vec_t;

  logic           clk, rst, tx_busy, tx_start, lock_drop;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;

  uart_tx_arb #(.N_REQ(N), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .lock_drop(lock_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  item_t      src_q [N][$];
  txev_t      tx_log[$];
  int         drop_log[$];
  int         gap[N], acc_cyc[N], first_rdy[N];
  int         cyc, busy_cnt, busy_min, busy_max, gap_max;
  int         checks, failures;
  logic [N-1:0] r_s, g_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_byte(input int s, input logic [7:0] d, input logic l);
    src_q[s].push_back('{d, l});
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && gap[i] == 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_q[i][0].data;
        req_last[i]        = src_q[i][0].last;
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: sample at negedge, then update sources and the UART core model after posedge.
  task automatic tick();
    logic [N-1:0] acc;
    logic         start_seen;
    item_t        it;
    @(negedge clk);
    r_s = req_ready;
    g_s = grant;
    acc = req_valid & req_ready;
    check("ready_legal", ((req_ready & ~req_valid) == '0) && $onehot0(req_ready), 1);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) acc_cyc[i] = cyc;
      if (acc[i] && first_rdy[i] < 0) first_rdy[i] = cyc;
    end
    start_seen = tx_start;
    if (tx_start) tx_log.push_back('{tx_data, grant, cyc});
    if (lock_drop) drop_log.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        it = src_q[i].pop_front();
        if (!it.last) gap[i] = $urandom_range(gap_max, 0);
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
    end
    if (start_seen) busy_cnt = $urandom_range(busy_max, busy_min);
    if (busy_cnt > 0) begin
      tx_busy = 1'b1;
      busy_cnt--;
    end else begin
      tx_busy = 1'b0;
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      gap[i]       = 0;
      first_rdy[i] = -1;
      acc_cyc[i]   = -1;
    end
    drive();
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_lock_drop", lock_drop, 0);
    rst = 1'b0;
    tx_log.delete();
    drop_log.delete();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int limit);
    for (int n = 0; n < limit; n++) begin
      if (all_empty() && grant == '0) return;
      tick();
    end
    check("idle_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[9];
    logic [7:0] hi[5];
    item_t      model_q[N][$];
    int         len_q[N][$];
    txev_t      exp_q[$];
    int         mi[N], bi[N];
    int         ptr, s, s_cyc, n;

    checks = 0; failures = 0; cyc = 0; busy_cnt = 0;
    rst = 1'b1; tx_busy = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    busy_min = 2; busy_max = 2; gap_max = 0;

    // prev: requester that sends one message first (moves the pointer to prev+1); 4 = none.
    vecs = '{
      '{4, 4'b0001, 4'b0001, 8'hC0},
      '{4, 4'b1010, 4'b0010, 8'hC1},
      '{4, 4'b1000, 4'b1000, 8'hC3},
      '{1, 4'b0110, 4'b0100, 8'hC2},
      '{3, 4'b1111, 4'b0001, 8'hC0},
      '{2, 4'b0011, 4'b0001, 8'hC0},
      '{0, 4'b1001, 4'b1000, 8'hC3},
      '{2, 4'b0100, 4'b0100, 8'hC2},
      '{4, 4'b0000, 4'b0000, 8'h00}
    };
    for (int v = 0; v < 9; v++) begin
      do_reset();
      if (vecs[v].prev < N) begin
        push_byte(vecs[v].prev, 8'h11, 1'b1);
        drive();
        wait_idle(200);
      end
      tx_log.delete();
      for (int i = 0; i < N; i++) if (vecs[v].valid[i]) push_byte(i, 8'hC0 + 8'(i), 1'b1);
      drive();
      tick();
      check($sformatf("vec%0d_ready", v), r_s, vecs[v].exp_ready);
      wait_idle(200);
      check($sformatf("vec%0d_count", v), tx_log.size(), $countones(vecs[v].valid));
      if (tx_log.size() > 0) check($sformatf("vec%0d_data", v), tx_log[0].data, vecs[v].exp_data);
    end

    // Single byte, core busy for 10 cycles.
    do_reset();
    busy_min = 10; busy_max = 10;
    push_byte(0, 8'h48, 1'b1);
    drive();
    for (n = 0; n < 50 && tx_log.size() == 0; n++) tick();
    check("single_started", tx_log.size(), 1);
    if (tx_log.size() == 1) begin
      check("single_latency", tx_log[0].cyc, acc_cyc[0] + 1);
      check("single_data", tx_log[0].data, 8'h48);
      check("single_grant", tx_log[0].grant, 4'b0001);
    end
    for (int k = 0; k < 11; k++) begin
      tick();
      check($sformatf("single_wait_grant%0d", k), g_s, 4'b0001);
    end
    tick();
    check("single_idle_grant", g_s, 4'b0000);

    // Lock: "Hi\r\n" from requester 0 while requester 1 waits with 0x41.
    do_reset();
    busy_min = 2; busy_max = 2; gap_max = 2;
    hi = '{8'h48, 8'h69, 8'h0D, 8'h0A, 8'h41};
    for (int k = 0; k < 4; k++) push_byte(0, hi[k], k == 3);
    push_byte(1, 8'h41, 1'b1);
    drive();
    wait_idle(400);
    check("lock_count", tx_log.size(), 5);
    if (tx_log.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("lock_data%0d", k), tx_log[k].data, hi[k]);
        check($sformatf("lock_grant%0d", k), tx_log[k].grant, (k == 4) ? 4'b0010 : 4'b0001);
        if (k > 0) check($sformatf("lock_gap%0d", k), (tx_log[k].cyc - tx_log[k-1].cyc) >= 3, 1);
      end
      check("lock_ready1_late", first_rdy[1] > tx_log[3].cyc, 1);
    end
    gap_max = 0;

    // Round-robin: all four requesters stream single-byte messages.
    do_reset();
    busy_min = 1; busy_max = 1;
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_byte(i, 8'hA0 + 8'(i), 1'b1);
    drive();
    wait_idle(400);
    check("rr_count", tx_log.size(), 8);
    if (tx_log.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("rr_data%0d", k), tx_log[k].data, 8'hA0 + 8'(k % 4));
        check($sformatf("rr_grant%0d", k), tx_log[k].grant, 4'b0001 << (k % 4));
      end
    end

    // Reset during WAIT of byte 2 of 5 from requester 3, pointer previously at 2.
    do_reset();
    busy_min = 4; busy_max = 4;
    push_byte(1, 8'h11, 1'b1);
    drive();
    wait_idle(200);
    tx_log.delete();
    for (int k = 0; k < 5; k++) push_byte(3, 8'h31 + 8'(k), k == 4);
    drive();
    for (n = 0; n < 200 && tx_log.size() < 2; n++) tick();
    check("mrst_two_starts", tx_log.size(), 2);
    rst = 1'b1;
    tick();
    check("mrst_tx_start", tx_start, 0);
    check("mrst_grant", grant, 0);
    check("mrst_lock_drop", lock_drop, 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin src_q[i].delete(); gap[i] = 0; end
    tx_log.delete();
    push_byte(0, 8'h01, 1'b1);
    push_byte(3, 8'h03, 1'b1);
    drive();
    wait_idle(200);
    check("mrst_count", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check("mrst_first", tx_log[0].data, 8'h01);
      check("mrst_first_grant", tx_log[0].grant, 4'b0001);
      check("mrst_second", tx_log[1].data, 8'h03);
    end

    // Stalled lock: requester 0 sends a non-last byte and goes quiet.
    do_reset();
    busy_min = 1; busy_max = 1;
    push_byte(0, 8'h55, 1'b0);
    push_byte(1, 8'h66, 1'b1);
    drive();
    for (n = 0; n < 50 && tx_log.size() == 0; n++) tick();
    s_cyc = (tx_log.size() > 0) ? tx_log[0].cyc : -1;
    for (int k = 0; k < 40; k++) tick();
`ifdef TX_ARB_TIMEOUT_EN
    // START at s_cyc, WAIT two cycles with one busy cycle, HOLD from s_cyc+3, pulse 20 cycles later.
    check("to_drop_count", drop_log.size(), 1);
    if (drop_log.size() == 1) check("to_drop_cycle", drop_log[0], s_cyc + 23);
    wait_idle(200);
    check("to_count", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check("to_next_data", tx_log[1].data, 8'h66);
      check("to_next_grant", tx_log[1].grant, 4'b0010);
    end
`else
    check("hold_no_drop", drop_log.size(), 0);
    check("hold_count", tx_log.size(), 1);
    check("hold_grant", grant, 4'b0001);
`endif

    // Randomized messages against a message-level round-robin model.
    do_reset();
    busy_min = 1; busy_max = 6; gap_max = 3;
    for (int i = 0; i < N; i++) begin
      len_q[i].delete();
      for (int m = 0; m < int'($urandom_range(3, 1)); m++) begin
        n = $urandom_range(4, 1);
        len_q[i].push_back(n);
        for (int j = 0; j < n; j++) push_byte(i, 8'($urandom), j == n - 1);
      end
      model_q[i] = src_q[i];
      mi[i] = 0;
      bi[i] = 0;
    end
    exp_q.delete();
    ptr = 0;
    for (int t = 0; t < 64; t++) begin
      s = -1;
      for (int k = 0; k < N; k++)
        if (s < 0 && mi[(ptr + k) % N] < len_q[(ptr + k) % N].size()) s = (ptr + k) % N;
      if (s < 0) break;
      for (int j = 0; j < len_q[s][mi[s]]; j++) begin
        exp_q.push_back('{model_q[s][bi[s]].data, 4'b0001 << s, 0});
        bi[s]++;
      end
      mi[s]++;
      ptr = (s + 1) % N;
    end
    drive();
    wait_idle(20000);
    check("rand_count", tx_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < tx_log.size(); k++) begin
      check($sformatf("rand_data%0d", k), tx_log[k].data, exp_q[k].data);
      check($sformatf("rand_grant%0d", k), tx_log[k].grant, exp_q[k].grant);
      if (k > 0) check($sformatf("rand_gap%0d", k), (tx_log[k].cyc - tx_log[k-1].cyc) >= 3, 1);
    end
    check("rand_no_drop", drop_log.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
